button_conditioner: RTL and testbench

- Conditions a raw push-button into a clean FIFO strobe; sits directly upstream of the FIFO and replaces the plain debounce stage in front of its clock/strobe input.
- Synchronises the pad and debounces with a consecutive-sample counter.
- Outputs a debounced level, a one-cycle press pulse, a one-cycle release pulse, and an optional auto-repeat press pulse while the button is held.
- Runs on the slow clock from clk_gen, nominally 5 kHz.

---
 rtl/button_pkg.sv | 17 +
 rtl/sync_2ff.sv | 25 ++
 rtl/button_conditioner.sv | 132 +++++++++++++
 tb/tb_button_conditioner.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared state encoding and default 5 kHz timing for the button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Defaults for a 5 kHz block clock
  localparam int unsigned CNT_W_DEF        = 16;
  localparam int unsigned DEBOUNCE_CYC_DEF = 100;   // 20 ms
  localparam int unsigned REPEAT_DELAY_DEF = 2500;  // 0.5 s
  localparam int unsigned REPEAT_RATE_DEF  = 500;   // 0.1 s

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Shift the pad value through two flops to settle metastability
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronise, debounce, and emit press/release
// strobes plus optional auto-repeat presses while held.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter bit          REPEAT_EN    = 1'b0,
  parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic button_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic held_o
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             held_q, held_d;
  logic             btn_s;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (button_i),
    .q_o   (btn_s)
  );

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      held_q    <= held_d;
    end
  end

  // Next-state, debounce counting and repeat scheduling
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    level_d   = level_q;
    held_d    = held_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          rcnt_d  = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (REPEAT_EN) begin
          // held_q doubles as "first repeat already fired"
          if (rcnt_q == (held_q ? RATE_LAST : DELAY_LAST)) begin
            press_d = 1'b1;
            held_d  = 1'b1;
            rcnt_d  = '0;
          end else if (rcnt_q != CNT_MAX) begin
            rcnt_d = rcnt_q + CNT_W'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to high resumes HELD with the repeat timer frozen
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          held_d    = 1'b0;
          release_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign held_o    = held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: dut0 (debounce 4, no repeat), dut1 (debounce 4, repeat
// 10/3), dut2 (debounce 1) share clock, reset and button.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic button = 1'b0;

  logic lvl0, prs0, rel0, hld0;
  logic lvl1, prs1, rel1, hld1;
  logic lvl2, prs2, rel2, hld2;

  int tests = 0;
  int fails = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  button_conditioner #(.CNT_W(16), .DEBOUNCE_CYC(4), .REPEAT_EN(1'b0),
                       .REPEAT_DELAY(10), .REPEAT_RATE(3)) dut0 (
    .clk(clk), .reset(reset), .button_i(button),
    .level_o(lvl0), .press_o(prs0), .release_o(rel0), .held_o(hld0));

  button_conditioner #(.CNT_W(16), .DEBOUNCE_CYC(4), .REPEAT_EN(1'b1),
                       .REPEAT_DELAY(10), .REPEAT_RATE(3)) dut1 (
    .clk(clk), .reset(reset), .button_i(button),
    .level_o(lvl1), .press_o(prs1), .release_o(rel1), .held_o(hld1));

  button_conditioner #(.CNT_W(8), .DEBOUNCE_CYC(1), .REPEAT_EN(1'b0),
                       .REPEAT_DELAY(10), .REPEAT_RATE(3)) dut2 (
    .clk(clk), .reset(reset), .button_i(button),
    .level_o(lvl2), .press_o(prs2), .release_o(rel2), .held_o(hld2));

  typedef struct {
    logic btn;
    logic lvl;
    logic prs;
    logic rel;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
    if (prs0 && rel0) overlap++;
  endtask

  task automatic seg(input int n, input logic b, input logic l);
    for (int i = 0; i < n; i++) vecs.push_back('{b, l, 1'b0, 1'b0});
  endtask

  task automatic idle_steps(input int n);
    button = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  int first_p, np, nrel, wr_cnt;
  logic bounce[29];

  initial begin
    // Reset state, applied asynchronously before any clock edge
    #2 reset = 1'b0;
    #1;
    chk("rst_level", int'(lvl0), 0);
    chk("rst_press", int'(prs0), 0);
    chk("rst_release", int'(rel0), 0);
    chk("rst_held", int'(hld1), 0);
    #20 reset = 1'b1;
    idle_steps(4);

    // Clean press/release, bounce rejection, release glitch rejection
    seg(6, 1'b1, 1'b0); seg(4, 1'b1, 1'b1); seg(6, 1'b0, 1'b1); seg(2, 1'b0, 1'b0);
    seg(3, 1'b1, 1'b0); seg(1, 1'b0, 1'b0); seg(2, 1'b1, 1'b0); seg(7, 1'b0, 1'b0);
    seg(6, 1'b1, 1'b0); seg(4, 1'b1, 1'b1); seg(2, 1'b0, 1'b1); seg(8, 1'b1, 1'b1);
    seg(6, 1'b0, 1'b1); seg(2, 1'b0, 1'b0);
    vecs[6].prs = 1'b1;
    vecs[16].rel = 1'b1;
    vecs[37].prs = 1'b1;
    vecs[57].rel = 1'b1;
    foreach (vecs[i]) begin
      button = vecs[i].btn;
      step();
      chk($sformatf("vec%0d_level", i), int'(lvl0), int'(vecs[i].lvl));
      chk($sformatf("vec%0d_press", i), int'(prs0), int'(vecs[i].prs));
      chk($sformatf("vec%0d_release", i), int'(rel0), int'(vecs[i].rel));
    end
    idle_steps(6);

    // Auto-repeat hold (dut1) alongside no-repeat (dut0) and debounce 1 (dut2)
    for (int s = 0; s < 46; s++) begin
      button = (s < 36);
      step();
      chk($sformatf("rpt%0d_press", s), int'(prs1),
          int'((s == 6) || (s >= 16 && s <= 37 && (s - 16) % 3 == 0)));
      chk($sformatf("rpt%0d_held", s), int'(hld1), int'(s >= 16 && s <= 41));
      chk($sformatf("rpt%0d_release", s), int'(rel1), int'(s == 42));
      chk($sformatf("rpt%0d_level", s), int'(lvl1), int'(s >= 6 && s <= 41));
      chk($sformatf("norpt%0d_press", s), int'(prs0), int'(s == 6));
      chk($sformatf("norpt%0d_held", s), int'(hld0), 0);
      chk($sformatf("deb1_%0d_press", s), int'(prs2), int'(s == 3));
      chk($sformatf("deb1_%0d_release", s), int'(rel2), int'(s == 39));
    end
    idle_steps(6);

    // Reset mid-PRESS_WAIT
    button = 1'b1;
    for (int i = 0; i < 4; i++) step();
    #2 reset = 1'b0;
    #1;
    chk("rstpw_level", int'(lvl0), 0);
    chk("rstpw_press", int'(prs0), 0);
    #3 reset = 1'b1;
    np = 0; first_p = -1; nrel = 0;
    for (int s = 0; s < 20; s++) begin
      step();
      if (prs0) begin np++; if (first_p < 0) first_p = s; end
      if (rel0) nrel++;
    end
    chk("rstpw_npress", np, 1);
    chk("rstpw_first", first_p, 6);
    chk("rstpw_nrel", nrel, 0);
    chk("prerst_held", int'(hld1), 1);
    chk("prerst_level", int'(lvl1), 1);

    // Reset mid-HELD with repeats active: outputs drop without a clock edge
    #2 reset = 1'b0;
    #1;
    chk("rsthd_level0", int'(lvl0), 0);
    chk("rsthd_level1", int'(lvl1), 0);
    chk("rsthd_held1", int'(hld1), 0);
    chk("rsthd_press1", int'(prs1), 0);
    chk("rsthd_release1", int'(rel1), 0);
    #3 reset = 1'b1;
    np = 0; first_p = -1; nrel = 0;
    for (int s = 0; s < 12; s++) begin
      step();
      if (prs0) begin np++; if (first_p < 0) first_p = s; end
      if (rel0 || rel1) nrel++;
    end
    chk("rsthd_npress", np, 1);
    chk("rsthd_first", first_p, 6);
    chk("rsthd_nrel", nrel, 0);
    idle_steps(12);

    // Four bouncy presses into a depth-4 write model
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
               1'b0, 1'b1, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    wr_cnt = 0;
    for (int p = 0; p < 4; p++) begin
      np = 0; nrel = 0;
      for (int i = 0; i < 29; i++) begin
        button = bounce[i];
        step();
        if (prs0) np++;
        if (rel0) nrel++;
      end
      wr_cnt += np;
      chk($sformatf("fifo_p%0d_writes", p), np, 1);
      chk($sformatf("fifo_p%0d_releases", p), nrel, 1);
      chk($sformatf("fifo_p%0d_full", p), int'(wr_cnt >= 4), int'(p == 3));
    end
    chk("fifo_total", wr_cnt, 4);
    chk("no_press_release_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
